// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and address-select constants for the cache controller
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_BACK = 2'd1,
      ALLOCATE   = 2'd2
   } t_cache_state;

   localparam logic ADDR_SEL_REQ    = 1'b0;
   localparam logic ADDR_SEL_VICTIM = 1'b1;

endpackage

// File: rtl/cache_word_counter.sv
// rtl/cache_word_counter.sv - word index counter for line write-back and refill
// Wraps explicitly after the last word so BLOCK_WORDS need not fill the counter width.
module cache_word_counter #(
   parameter int  BLOCK_WORDS = 16,
   localparam int WORD_IDX_W  = $clog2(BLOCK_WORDS)
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  inc,
   input  logic                  clr,
   output logic [WORD_IDX_W-1:0] count,
   output logic                  at_last
);

   localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(BLOCK_WORDS - 1);

   assign at_last = (count == LAST_IDX);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= at_last ? '0 : count + WORD_IDX_W'(1);
      end
   end

endmodule

// File: rtl/dcache_fsm.sv
// rtl/dcache_fsm.sv - cache controller FSM: hit service, dirty victim write-back, word-by-word refill
// All outputs are combinational from the state, the word counter and the current inputs.
module dcache_fsm
   import cache_pkg::*;
#(
   parameter int  BLOCK_WORDS = 16,
   parameter int  WB_EN       = 1,
   localparam int WORD_IDX_W  = $clog2(BLOCK_WORDS)
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_req_valid,
   input  logic                  i_req_write,
   input  logic                  i_cache_hit,
   input  logic                  i_victim_dirty,
   input  logic                  i_axi_read_done,
   input  logic                  i_axi_write_done,
   output logic                  o_stall,
   output logic                  o_axi_read_start,
   output logic                  o_axi_write_start,
   output logic                  o_addr_sel,
   output logic [WORD_IDX_W-1:0] o_word_idx,
   output logic                  o_block_we,
   output logic                  o_line_valid_set,
   output logic                  o_data_we,
   output logic                  o_dirty_set,
   output logic                  o_lru_update
);

   t_cache_state ps;
   t_cache_state ns;

   logic wb_on;
   logic miss;
   logic dirty_miss;
   logic cnt_inc;
   logic cnt_clr;
   logic cnt_last;

   assign wb_on      = (WB_EN != 0);
   assign miss       = i_req_valid & ~i_cache_hit;
   assign dirty_miss = miss & i_victim_dirty & wb_on;

   cache_word_counter #(
      .BLOCK_WORDS(BLOCK_WORDS)
   ) u_word_counter (
      .clk    (i_clk),
      .arst   (i_arst),
      .inc    (cnt_inc),
      .clr    (cnt_clr),
      .count  (o_word_idx),
      .at_last(cnt_last)
   );

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         ps <= IDLE;
      end else begin
         ps <= ns;
      end
   end

   always_comb begin
      ns                = ps;
      cnt_inc           = 1'b0;
      cnt_clr           = 1'b0;
      o_stall           = 1'b0;
      o_axi_read_start  = 1'b0;
      o_axi_write_start = 1'b0;
      o_addr_sel        = ADDR_SEL_REQ;
      o_block_we        = 1'b0;
      o_line_valid_set  = 1'b0;
      o_data_we         = 1'b0;
      o_dirty_set       = 1'b0;
      o_lru_update      = 1'b0;

      case (ps)
         IDLE: begin
            // Done pulses are ignored here; the counter is held at word 0.
            cnt_clr      = 1'b1;
            o_lru_update = i_req_valid & i_cache_hit;
            o_data_we    = i_req_valid & i_cache_hit & i_req_write & wb_on;
            o_dirty_set  = i_req_valid & i_cache_hit & i_req_write & wb_on;
            o_stall      = miss;
            if (dirty_miss) begin
               o_axi_write_start = 1'b1;
               o_addr_sel        = ADDR_SEL_VICTIM;
               ns                = WRITE_BACK;
            end else if (miss) begin
               o_axi_read_start = 1'b1;
               ns               = ALLOCATE;
            end
         end

         WRITE_BACK: begin
            o_stall           = 1'b1;
            o_addr_sel        = ADDR_SEL_VICTIM;
            o_axi_write_start = ~i_axi_write_done;
            if (i_axi_write_done) begin
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  ns = ALLOCATE;
               end
            end
         end

         ALLOCATE: begin
            // The line becomes valid together with its final word write.
            o_stall          = 1'b1;
            o_axi_read_start = ~i_axi_read_done;
            o_block_we       = i_axi_read_done;
            if (i_axi_read_done) begin
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  o_line_valid_set = 1'b1;
                  ns               = IDLE;
               end
            end
         end

         default: begin
            cnt_clr = 1'b1;
            ns      = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_fsm.sv
// tb/tb_dcache_fsm.sv - directed table-driven bench for dcache_fsm with BLOCK_WORDS=4
module tb_dcache_fsm;

   logic clk = 1'b0;
   logic arst = 1'b1;

   // write-back instance
   logic rv = 1'b0, rw = 1'b0, hit = 1'b0, vd = 1'b0, rd = 1'b0, wd = 1'b0;
   logic stall, rs, ws, as_, bwe, lvs, dwe, ds, lru;
   logic [1:0] idx;
   logic [8:0] outs;

   // read-only instance
   logic b_rv = 1'b0, b_rw = 1'b0, b_hit = 1'b0, b_vd = 1'b0, b_rd = 1'b0, b_wd = 1'b0;
   logic b_stall, b_rs, b_ws, b_as, b_bwe, b_lvs, b_dwe, b_ds, b_lru;
   logic [1:0] b_idx;
   logic [8:0] b_outs;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dcache_fsm #(.BLOCK_WORDS(4), .WB_EN(1)) dut (
      .i_clk(clk), .i_arst(arst),
      .i_req_valid(rv), .i_req_write(rw), .i_cache_hit(hit), .i_victim_dirty(vd),
      .i_axi_read_done(rd), .i_axi_write_done(wd),
      .o_stall(stall), .o_axi_read_start(rs), .o_axi_write_start(ws), .o_addr_sel(as_),
      .o_word_idx(idx), .o_block_we(bwe), .o_line_valid_set(lvs),
      .o_data_we(dwe), .o_dirty_set(ds), .o_lru_update(lru)
   );

   dcache_fsm #(.BLOCK_WORDS(4), .WB_EN(0)) dut_ro (
      .i_clk(clk), .i_arst(arst),
      .i_req_valid(b_rv), .i_req_write(b_rw), .i_cache_hit(b_hit), .i_victim_dirty(b_vd),
      .i_axi_read_done(b_rd), .i_axi_write_done(b_wd),
      .o_stall(b_stall), .o_axi_read_start(b_rs), .o_axi_write_start(b_ws), .o_addr_sel(b_as),
      .o_word_idx(b_idx), .o_block_we(b_bwe), .o_line_valid_set(b_lvs),
      .o_data_we(b_dwe), .o_dirty_set(b_ds), .o_lru_update(b_lru)
   );

   // {stall, read_start, write_start, addr_sel, block_we, line_valid_set, data_we, dirty_set, lru_update}
   assign outs   = {stall, rs, ws, as_, bwe, lvs, dwe, ds, lru};
   assign b_outs = {b_stall, b_rs, b_ws, b_as, b_bwe, b_lvs, b_dwe, b_ds, b_lru};

   typedef struct {
      logic [5:0] in;   // {req_valid, req_write, hit, victim_dirty, read_done, write_done}
      logic [8:0] exp;
      logic [1:0] idx;
   } vec_t;

   vec_t vecs[30];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [5:0] in);
      @(negedge clk);
      {rv, rw, hit, vd, rd, wd} = in;
      #1;
   endtask

   task automatic step_ro(input logic [5:0] in);
      @(negedge clk);
      {b_rv, b_rw, b_hit, b_vd, b_rd, b_wd} = in;
      #1;
   endtask

   initial begin
      vecs[0]  = '{6'b000000, 9'b000000000, 2'd0};  // idle
      vecs[1]  = '{6'b101000, 9'b000000001, 2'd0};  // read hit
      vecs[2]  = '{6'b111000, 9'b000000111, 2'd0};  // store hit
      vecs[3]  = '{6'b100000, 9'b110000000, 2'd0};  // clean miss
      vecs[4]  = '{6'b100000, 9'b110000000, 2'd0};
      vecs[5]  = '{6'b100000, 9'b110000000, 2'd0};
      vecs[6]  = '{6'b100000, 9'b110000000, 2'd0};
      vecs[7]  = '{6'b100010, 9'b100010000, 2'd0};
      vecs[8]  = '{6'b100000, 9'b110000000, 2'd1};
      vecs[9]  = '{6'b100001, 9'b110000000, 2'd1};  // stray write_done
      vecs[10] = '{6'b100010, 9'b100010000, 2'd1};
      vecs[11] = '{6'b100010, 9'b100010000, 2'd2};
      vecs[12] = '{6'b100000, 9'b110000000, 2'd3};
      vecs[13] = '{6'b100010, 9'b100011000, 2'd3};  // last word, line valid
      vecs[14] = '{6'b101000, 9'b000000001, 2'd0};  // refilled line hits
      vecs[15] = '{6'b110100, 9'b101100000, 2'd0};  // dirty store miss
      vecs[16] = '{6'b110100, 9'b101100000, 2'd0};
      vecs[17] = '{6'b110101, 9'b100100000, 2'd0};
      vecs[18] = '{6'b110110, 9'b101100000, 2'd1};  // stray read_done
      vecs[19] = '{6'b110101, 9'b100100000, 2'd1};
      vecs[20] = '{6'b110101, 9'b100100000, 2'd2};
      vecs[21] = '{6'b110100, 9'b101100000, 2'd3};
      vecs[22] = '{6'b110101, 9'b100100000, 2'd3};
      vecs[23] = '{6'b110100, 9'b110000000, 2'd0};  // refill after write-back
      vecs[24] = '{6'b110110, 9'b100010000, 2'd0};
      vecs[25] = '{6'b110110, 9'b100010000, 2'd1};
      vecs[26] = '{6'b110110, 9'b100010000, 2'd2};
      vecs[27] = '{6'b110110, 9'b100011000, 2'd3};
      vecs[28] = '{6'b111000, 9'b000000111, 2'd0};  // store completes as hit
      vecs[29] = '{6'b000011, 9'b000000000, 2'd0};  // done pulses in idle

      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {outs, idx}, 11'd0);
      @(negedge clk);
      arst = 1'b0;

      for (int i = 0; i < 30; i++) begin
         step(vecs[i].in);
         check($sformatf("vec[%0d]", i), {outs, idx}, {vecs[i].exp, vecs[i].idx});
      end

      // reset during refill at word 2
      step(6'b100000);
      check("rst_miss_start", {outs, idx}, {9'b110000000, 2'd0});
      step(6'b100000);
      step(6'b100010);
      step(6'b100010);
      step(6'b100000);
      check("rst_pre_idx", {outs, idx}, {9'b110000000, 2'd2});
      rv   = 1'b0;
      arst = 1'b1;
      #1;
      check("rst_mid_alloc", {outs, idx}, 11'd0);
      @(negedge clk);
      arst = 1'b0;
      step(6'b100000);
      check("rst_remiss_idle", {outs, idx}, {9'b110000000, 2'd0});
      step(6'b100000);
      check("rst_remiss_alloc", {outs, idx}, {9'b110000000, 2'd0});
      for (int k = 0; k < 4; k++) begin
         step(6'b100010);
         check($sformatf("rst_refill[%0d]", k), {outs, idx},
               {(k == 3) ? 9'b100011000 : 9'b100010000, 2'(k)});
      end
      step(6'b101000);
      check("rst_refill_hit", {outs, idx}, {9'b000000001, 2'd0});
      step(6'b000000);

      // read-only mode: dirty victim never written back, stores never write the array
      step_ro(6'b100100);
      check("ro_miss", {b_outs, b_idx}, {9'b110000000, 2'd0});
      for (int k = 0; k < 4; k++) begin
         step_ro(6'b100110);
         check($sformatf("ro_refill[%0d]", k), {b_outs, b_idx},
               {(k == 3) ? 9'b100011000 : 9'b100010000, 2'(k)});
      end
      step_ro(6'b111100);
      check("ro_store_hit", {b_outs, b_idx}, {9'b000000001, 2'd0});
      step_ro(6'b000000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_fsm.md
Name: dcache_fsm

Overview:
- Cache controller FSM for a set-associative data or instruction cache; sits between the core's memory stage and the AXI4-Lite master engine.
- Adds write-back of dirty victims and word-by-word block refill: one single-beat AXI4-Lite transaction per word, with a word counter.
- Drives the cache arrays' write strobes, dirty/valid/LRU updates and the core stall.
- WB_EN=0 gives a read-only (instruction-cache) mode with no write-back path.

Parameters:
- BLOCK_WORDS, 16, words per cache line; power of two, >= 2.
- WORD_IDX_W, $clog2(BLOCK_WORDS), width of the word index (derived, not overridden).
- WB_EN, 1, 1 = write-back enabled; 0 = i_victim_dirty and i_req_write ignored, no WRITE_BACK state reachable.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  async reset, active-high.
- i_req_valid  in  1  core access pending this cycle.
- i_req_write  in  1  access is a store.
- i_cache_hit  in  1  tag lookup hit, combinational from arrays.
- i_victim_dirty  in  1  selected victim line is valid and dirty.
- i_axi_read_done  in  1  single-cycle pulse: current word read returned.
- i_axi_write_done  in  1  single-cycle pulse: current word write acknowledged.
- o_stall  out  1  freeze core.
- o_axi_read_start  out  1  request/hold AXI read of word o_word_idx.
- o_axi_write_start  out  1  request/hold AXI write of victim word o_word_idx.
- o_addr_sel  out  1  0 = request line address, 1 = victim line address (for AXI).
- o_word_idx  out  WORD_IDX_W  word offset of the current AXI transfer.
- o_block_we  out  1  write the returned read word into line[o_word_idx].
- o_line_valid_set  out  1  mark refilled line valid, clean; update its tag.
- o_data_we  out  1  store-hit write into cache data array.
- o_dirty_set  out  1  set dirty bit of hit line.
- o_lru_update  out  1  update replacement state for hit line.

Behaviour:
- Reset: async; PS=IDLE, word counter=0. All outputs are combinational from state and inputs, so they read 0 in IDLE with i_req_valid=0.
- miss = i_req_valid & ~i_cache_hit. dirty_miss = miss & i_victim_dirty & WB_EN.
- IDLE:
  - o_lru_update = i_req_valid & i_cache_hit.
  - o_data_we = o_dirty_set = i_req_valid & i_cache_hit & i_req_write & WB_EN.
  - o_stall = miss.
  - dirty_miss: o_axi_write_start=1, o_addr_sel=1, NS=WRITE_BACK.
  - Clean miss: o_axi_read_start=1, NS=ALLOCATE.
  - Done pulses in IDLE are ignored.
- WRITE_BACK:
  - o_stall=1, o_addr_sel=1, o_axi_write_start = ~i_axi_write_done.
  - On i_axi_write_done: counter increments.
  - If counter == BLOCK_WORDS-1 on that pulse: counter wraps to 0, NS=ALLOCATE.
  - Start drops for exactly the done cycle; the next word's start rises the following cycle.
- ALLOCATE:
  - o_stall=1, o_addr_sel=0, o_axi_read_start = ~i_axi_read_done.
  - o_block_we = i_axi_read_done, with o_word_idx = current count.
  - On done: counter increments.
  - On the last word (count == BLOCK_WORDS-1): o_line_valid_set=1 in the same cycle, counter wraps to 0, NS=IDLE.
- After refill, IDLE re-evaluates the lookup. The hit is served with no extra stall cycle; a store completes via the IDLE write-hit path.
- Latency, clean miss: BLOCK_WORDS read transactions, then 1 IDLE cycle.
- Latency, dirty miss: BLOCK_WORDS writes, then BLOCK_WORDS reads.
- o_word_idx = counter in all states; 0 in IDLE.
- Wrong-direction done pulses are ignored: read_done in WRITE_BACK, write_done in ALLOCATE.
- Reset mid-operation: immediate return to IDLE with counter 0. No partial-line valid is set. An AXI transaction already in flight is the AXI engine's responsibility to drain.
- i_req_valid, i_req_write and the address must be held stable by the core while o_stall=1.
- Counter arithmetic is WORD_IDX_W bits wide; wrap is explicit, not overflow-dependent.
- No illegal states. The default branch returns to IDLE with all outputs 0.

Decomposition:
- Package cache_pkg:
  - t_cache_state enum {IDLE, WRITE_BACK, ALLOCATE}, 2-bit.
  - ADDR_SEL_REQ / ADDR_SEL_VICTIM constants.
- One sub-module, cache_word_counter: counter with inc, clr and wrap-at-(BLOCK_WORDS-1) flag.
- FSM next-state and output logic stay in dcache_fsm.

Test Plan:
- BLOCK_WORDS=4, WB_EN=1; read hit, i_req_valid=1 → o_stall=0, o_lru_update=1, no AXI start.
- Store hit → o_data_we=1, o_dirty_set=1 same cycle; o_stall=0.
- Clean miss, read_done pulses separated by 3 cycles → o_block_we pulses with o_word_idx 0,1,2,3; o_line_valid_set on the 4th; o_stall falls the cycle after the line turns valid (hit).
- Dirty miss → 4 write_start/done cycles with o_addr_sel=1 and idx 0..3, then 4 reads with o_addr_sel=0, then IDLE. A stray read_done during WRITE_BACK does not advance the counter.
- WB_EN=0, i_victim_dirty=1 miss → goes directly to ALLOCATE, o_axi_write_start never 1; store hit gives o_data_we=0.
- i_arst asserted in ALLOCATE at idx=2 → same-cycle PS=IDLE, o_stall=0, o_word_idx=0, no o_line_valid_set; next miss refills from idx 0.
